// File: rtl/ball_motion.sv
// Per-frame ball position engine: advances and bounces a square ball at the start of vertical blanking.
// Also produces a registered inside-ball flag for the pixel currently being scanned.
module ball_motion #(
    parameter int FIELD_W   = 1280,
    parameter int FIELD_H   = 1024,
    parameter int BALL_SIZE = 16,
    parameter int SPEED_X   = 4,
    parameter int SPEED_Y   = 3,
    parameter int INIT_X    = 632,
    parameter int INIT_Y    = 504
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] display_col,
    input  logic [10:0] display_row,
    input  logic        enable,
    output logic [11:0] ball_x,
    output logic [10:0] ball_y,
    output logic        dir_x,
    output logic        dir_y,
    output logic        bounce,
    output logic        corner,
    output logic        in_ball,
    output logic [15:0] frame_count
);

    typedef enum logic [1:0] {
        IDLE,
        UPD_X,
        UPD_Y,
        COMMIT
    } state_t;

    localparam logic [12:0] X_MAX13   = 13'(FIELD_W - BALL_SIZE);
    localparam logic [11:0] X_MAX12   = 12'(FIELD_W - BALL_SIZE);
    localparam logic [11:0] Y_MAX12   = 12'(FIELD_H - BALL_SIZE);
    localparam logic [10:0] Y_MAX11   = 11'(FIELD_H - BALL_SIZE);
    localparam logic [12:0] SX13      = 13'(SPEED_X);
    localparam logic [11:0] SX12      = 12'(SPEED_X);
    localparam logic [11:0] SY12      = 12'(SPEED_Y);
    localparam logic [10:0] SY11      = 11'(SPEED_Y);
    localparam logic [12:0] SIZE13    = 13'(BALL_SIZE);
    localparam logic [11:0] SIZE12    = 12'(BALL_SIZE);
    localparam logic [11:0] COL_LIMIT = 12'(FIELD_W);
    localparam logic [10:0] ROW_LIMIT = 11'(FIELD_H);

    state_t      state_q, state_d;
    logic [11:0] nx, nx_d;
    logic [10:0] ny, ny_d;
    logic        ndx, ndx_d;
    logic        ndy, ndy_d;
    logic        hit_x, hit_x_d;
    logic        hit_y, hit_y_d;
    logic        commit;
    logic        count_frame;
    logic        start;
    logic [12:0] sum_x;
    logic [11:0] sum_y;
    logic [12:0] col_end;
    logic [11:0] row_end;
    logic        in_ball_d;

    assign start = (display_col == 12'd0) && (display_row == ROW_LIMIT);

    // Extended sums so the right/bottom edge compare cannot wrap.
    assign sum_x = {1'b0, nx} + SX13;
    assign sum_y = {1'b0, ny} + SY12;

    always_comb begin
        state_d     = state_q;
        nx_d        = nx;
        ny_d        = ny;
        ndx_d       = ndx;
        ndy_d       = ndy;
        hit_x_d     = hit_x;
        hit_y_d     = hit_y;
        commit      = 1'b0;
        count_frame = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    count_frame = 1'b1;
                    if (enable) begin
                        state_d = UPD_X;
                        nx_d    = ball_x;
                        ny_d    = ball_y;
                        ndx_d   = dir_x;
                        ndy_d   = dir_y;
                    end
                end
            end
            UPD_X: begin
                state_d = UPD_Y;
                if (ndx && (sum_x >= X_MAX13)) begin
                    nx_d    = X_MAX12;
                    ndx_d   = 1'b0;
                    hit_x_d = 1'b1;
                end else if (!ndx && (nx < SX12)) begin
                    nx_d    = 12'd0;
                    ndx_d   = 1'b1;
                    hit_x_d = 1'b1;
                end else if (ndx) begin
                    nx_d = nx + SX12;
                end else begin
                    nx_d = nx - SX12;
                end
            end
            UPD_Y: begin
                state_d = COMMIT;
                if (ndy && (sum_y >= Y_MAX12)) begin
                    ny_d    = Y_MAX11;
                    ndy_d   = 1'b0;
                    hit_y_d = 1'b1;
                end else if (!ndy && (ny < SY11)) begin
                    ny_d    = 11'd0;
                    ndy_d   = 1'b1;
                    hit_y_d = 1'b1;
                end else if (ndy) begin
                    ny_d = ny + SY11;
                end else begin
                    ny_d = ny - SY11;
                end
            end
            COMMIT: begin
                state_d = IDLE;
                commit  = 1'b1;
                hit_x_d = 1'b0;
                hit_y_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    assign col_end = {1'b0, ball_x} + SIZE13;
    assign row_end = {1'b0, ball_y} + SIZE12;

    always_comb begin
        in_ball_d = (display_col >= ball_x) && ({1'b0, display_col} < col_end) &&
                    (display_row >= ball_y) && ({1'b0, display_row} < row_end) &&
                    (display_col < COL_LIMIT) && (display_row < ROW_LIMIT);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            nx          <= 12'(INIT_X);
            ny          <= 11'(INIT_Y);
            ndx         <= 1'b1;
            ndy         <= 1'b1;
            hit_x       <= 1'b0;
            hit_y       <= 1'b0;
            ball_x      <= 12'(INIT_X);
            ball_y      <= 11'(INIT_Y);
            dir_x       <= 1'b1;
            dir_y       <= 1'b1;
            bounce      <= 1'b0;
            corner      <= 1'b0;
            in_ball     <= 1'b0;
            frame_count <= 16'd0;
        end else begin
            state_q <= state_d;
            nx      <= nx_d;
            ny      <= ny_d;
            ndx     <= ndx_d;
            ndy     <= ndy_d;
            hit_x   <= hit_x_d;
            hit_y   <= hit_y_d;
            // Position and direction change together so a frame never sees a half update.
            if (commit) begin
                ball_x <= nx;
                ball_y <= ny;
                dir_x  <= ndx;
                dir_y  <= ndy;
            end
            bounce  <= commit & (hit_x | hit_y);
            corner  <= commit & hit_x & hit_y;
            in_ball <= in_ball_d;
            if (count_frame) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_ball_motion.sv
// Directed bench for ball_motion: two instances (default start point and one near the bottom-right)
// stepped frame by frame against a position scoreboard.
module tb_ball_motion;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [11:0] display_col;
    logic [10:0] display_row;

    logic [11:0] a_ball_x, c_ball_x;
    logic [10:0] a_ball_y, c_ball_y;
    logic        a_dir_x, a_dir_y, a_bounce, a_corner, a_in_ball;
    logic        c_dir_x, c_dir_y, c_bounce, c_corner, c_in_ball;
    logic [15:0] a_frame_count, c_frame_count;

    always #5 clock = ~clock;

    ball_motion dut (
        .clock(clock), .reset(reset), .display_col(display_col), .display_row(display_row),
        .enable(enable), .ball_x(a_ball_x), .ball_y(a_ball_y), .dir_x(a_dir_x), .dir_y(a_dir_y),
        .bounce(a_bounce), .corner(a_corner), .in_ball(a_in_ball), .frame_count(a_frame_count)
    );

    ball_motion #(.INIT_X(1180), .INIT_Y(1005)) dut_c (
        .clock(clock), .reset(reset), .display_col(display_col), .display_row(display_row),
        .enable(enable), .ball_x(c_ball_x), .ball_y(c_ball_y), .dir_x(c_dir_x), .dir_y(c_dir_y),
        .bounce(c_bounce), .corner(c_corner), .in_ball(c_in_ball), .frame_count(c_frame_count)
    );

    typedef struct {
        int   x;
        int   y;
        logic dx;
        logic dy;
        logic bnc;
        logic crn;
    } pos_t;

    typedef struct {
        pos_t a;
        pos_t c;
        int   fc;
    } exp_t;

    exp_t sb[$];
    pos_t ma, mc;
    int   fc_exp;
    int   errors = 0;
    int   checks = 0;
    logic seen_a_bnc, seen_a_crn, seen_c_bnc, seen_c_crn;

    int   ib_col[10] = '{631, 632, 647, 648, 640, 640, 640, 1180, 1195, 1196};
    int   ib_row[10] = '{504, 504, 504, 504, 503, 519, 520, 1005, 1020, 1020};
    logic ib_a[10]   = '{0, 1, 1, 0, 0, 1, 0, 0, 0, 0};
    logic ib_c[10]   = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0};

    function automatic pos_t step(input pos_t p);
        pos_t r;
        logic hx, hy;
        r  = p;
        hx = 1'b0;
        hy = 1'b0;
        if (p.dx) begin
            if (p.x + 4 >= 1264) begin r.x = 1264; r.dx = 1'b0; hx = 1'b1; end
            else r.x = p.x + 4;
        end else begin
            if (p.x < 4) begin r.x = 0; r.dx = 1'b1; hx = 1'b1; end
            else r.x = p.x - 4;
        end
        if (p.dy) begin
            if (p.y + 3 >= 1008) begin r.y = 1008; r.dy = 1'b0; hy = 1'b1; end
            else r.y = p.y + 3;
        end else begin
            if (p.y < 3) begin r.y = 0; r.dy = 1'b1; hy = 1'b1; end
            else r.y = p.y - 3;
        end
        r.bnc = hx | hy;
        r.crn = hx & hy;
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        ma     = '{x: 632, y: 504, dx: 1'b1, dy: 1'b1, bnc: 1'b0, crn: 1'b0};
        mc     = '{x: 1180, y: 1005, dx: 1'b1, dy: 1'b1, bnc: 1'b0, crn: 1'b0};
        fc_exp = 0;
    endtask

    task automatic check_reset(input string p);
        check({p, "_a_x"}, 32'(a_ball_x), 32'd632);
        check({p, "_a_y"}, 32'(a_ball_y), 32'd504);
        check({p, "_a_dx"}, 32'(a_dir_x), 32'd1);
        check({p, "_a_dy"}, 32'(a_dir_y), 32'd1);
        check({p, "_a_bounce"}, 32'(a_bounce), 32'd0);
        check({p, "_a_corner"}, 32'(a_corner), 32'd0);
        check({p, "_a_in_ball"}, 32'(a_in_ball), 32'd0);
        check({p, "_a_fc"}, 32'(a_frame_count), 32'd0);
        check({p, "_c_x"}, 32'(c_ball_x), 32'd1180);
        check({p, "_c_y"}, 32'(c_ball_y), 32'd1005);
        check({p, "_c_fc"}, 32'(c_frame_count), 32'd0);
    endtask

    // One start pulse, then compare committed outputs four cycles later and the pulse end one cycle after.
    task automatic frame();
        exp_t e;
        @(negedge clock);
        display_col = 12'd0;
        display_row = 11'd1024;
        fc_exp++;
        if (enable) begin
            ma = step(ma);
            mc = step(mc);
        end else begin
            ma.bnc = 1'b0; ma.crn = 1'b0;
            mc.bnc = 1'b0; mc.crn = 1'b0;
        end
        sb.push_back('{a: ma, c: mc, fc: fc_exp});
        @(negedge clock);
        display_col = 12'd100;
        display_row = 11'd0;
        repeat (3) @(negedge clock);
        e = sb.pop_front();
        check("a_x", 32'(a_ball_x), 32'(e.a.x));
        check("a_y", 32'(a_ball_y), 32'(e.a.y));
        check("a_dx", 32'(a_dir_x), 32'(e.a.dx));
        check("a_dy", 32'(a_dir_y), 32'(e.a.dy));
        check("a_bounce", 32'(a_bounce), 32'(e.a.bnc));
        check("a_corner", 32'(a_corner), 32'(e.a.crn));
        check("c_x", 32'(c_ball_x), 32'(e.c.x));
        check("c_y", 32'(c_ball_y), 32'(e.c.y));
        check("c_dx", 32'(c_dir_x), 32'(e.c.dx));
        check("c_dy", 32'(c_dir_y), 32'(e.c.dy));
        check("c_bounce", 32'(c_bounce), 32'(e.c.bnc));
        check("c_corner", 32'(c_corner), 32'(e.c.crn));
        check("a_fc", 32'(a_frame_count), 32'(e.fc));
        seen_a_bnc = a_bounce;
        seen_a_crn = a_corner;
        seen_c_bnc = c_bounce;
        seen_c_crn = c_corner;
        @(negedge clock);
        check("a_bounce_end", 32'(a_bounce), 32'd0);
        check("c_bounce_end", 32'(c_bounce), 32'd0);
    endtask

    initial begin
        logic prev_a, prev_c;
        reset       = 1'b1;
        enable      = 1'b0;
        display_col = 12'd100;
        display_row = 11'd0;
        model_reset();
        repeat (2) @(negedge clock);
        check_reset("rst");
        reset = 1'b0;

        prev_a = 1'b0;
        prev_c = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            display_col = 12'(ib_col[i]);
            display_row = 11'(ib_row[i]);
            #1;
            check("in_ball_a_hold", 32'(a_in_ball), 32'(prev_a));
            @(negedge clock);
            check("in_ball_a", 32'(a_in_ball), 32'(ib_a[i]));
            check("in_ball_c", 32'(c_in_ball), 32'(ib_c[i]));
            prev_a = ib_a[i];
            prev_c = ib_c[i];
        end

        enable = 1'b0;
        repeat (3) frame();
        check("disabled_fc", 32'(a_frame_count), 32'd3);
        check("disabled_x", 32'(a_ball_x), 32'd632);
        check("disabled_y", 32'(a_ball_y), 32'd504);

        // Start an update, then hit reset while it is in the Y step.
        enable = 1'b1;
        @(negedge clock);
        display_col = 12'd0;
        display_row = 11'd1024;
        @(negedge clock);
        display_col = 12'd100;
        display_row = 11'd0;
        @(negedge clock);
        reset = 1'b1;
        #1;
        check_reset("mid");
        repeat (3) begin
            @(negedge clock);
            check("mid_a_bounce", 32'(a_bounce), 32'd0);
            check("mid_c_bounce", 32'(c_bounce), 32'd0);
            check("mid_a_x", 32'(a_ball_x), 32'd632);
        end
        reset = 1'b0;
        model_reset();

        for (int f = 1; f <= 338; f++) begin
            frame();
            if (f == 1) begin
                check("f1_a_x", 32'(a_ball_x), 32'd636);
                check("f1_a_y", 32'(a_ball_y), 32'd507);
                check("f1_a_bounce", 32'(seen_a_bnc), 32'd0);
                check("f1_a_fc", 32'(a_frame_count), 32'd1);
                check("f1_c_y", 32'(c_ball_y), 32'd1008);
                check("f1_c_bounce", 32'(seen_c_bnc), 32'd1);
                check("f1_c_corner", 32'(seen_c_crn), 32'd0);
            end
            if (f == 158) begin
                check("right_x", 32'(a_ball_x), 32'd1264);
                check("right_dx", 32'(a_dir_x), 32'd0);
                check("right_bounce", 32'(seen_a_bnc), 32'd1);
                check("right_corner", 32'(seen_a_crn), 32'd0);
            end
            if (f == 338) begin
                check("corner_x", 32'(c_ball_x), 32'd0);
                check("corner_y", 32'(c_ball_y), 32'd0);
                check("corner_dx", 32'(c_dir_x), 32'd1);
                check("corner_dy", 32'(c_dir_y), 32'd1);
                check("corner_bounce", 32'(seen_c_bnc), 32'd1);
                check("corner_corner", 32'(seen_c_crn), 32'd1);
                check("corner_fc", 32'(c_frame_count), 32'd338);
            end
        end
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
